// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding, forwarding selects and result-source codes
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {INIT, RUN, HALT, STEP} state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'h1;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/debug signals between the datapath (master) and the controller (slave)
interface pipeline_ctrl_if #(parameter int REG_ADDR_WIDTH = 5, parameter int CNT_WIDTH = 16);
  logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, Jump2E;
  logic halt_req, step_req, resume_req;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, FlushD, FlushE;
  logic halted, step_ack;
  logic [CNT_WIDTH-1:0] stall_count;
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE,
           PCSrcE, Jump2E, halt_req, step_req, resume_req,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, halted, step_ack, stall_count
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE,
           PCSrcE, Jump2E, halt_req, step_req, resume_req,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, halted, step_ack, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl_fwd_sel.sv
// fwd_sel: picks the ALU operand source for one Execute source index, Memory beating Writeback
module fwd_sel import pipeline_ctrl_pkg::*; #(
  parameter int W = 5
) (
  input  logic [W-1:0] rs_i,
  input  logic [W-1:0] rd_m_i,
  input  logic [W-1:0] rd_w_i,
  input  logic         we_m_i,
  input  logic         we_w_i,
  output logic [1:0]   sel_o
);
  assign sel_o = (we_m_i && rd_m_i != '0 && rd_m_i == rs_i) ? FWD_M :
                 (we_w_i && rd_w_i != '0 && rd_w_i == rs_i) ? FWD_W : FWD_RF;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard unit (forwarding, load-use stall, redirect flush) with debug run-control FSM
module pipeline_ctrl import pipeline_ctrl_pkg::*; #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH = 16,
  parameter int FLUSH_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  pipeline_ctrl_if.slave p
);
  localparam logic [3:0] INIT_LOAD = 4'(FLUSH_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] init_q, init_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic halted_q, lw_stall, redirect, active, hold;
  fwd_sel #(.W(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_i(p.Rs1E), .rd_m_i(p.RdM), .rd_w_i(p.RdW),
    .we_m_i(p.RegWriteM), .we_w_i(p.RegWriteW), .sel_o(p.ForwardAE)
  );
  fwd_sel #(.W(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_i(p.Rs2E), .rd_m_i(p.RdM), .rd_w_i(p.RdW),
    .we_m_i(p.RegWriteM), .we_w_i(p.RegWriteW), .sel_o(p.ForwardBE)
  );
  assign lw_stall = p.ResultSrcE == RESULT_SRC_LOAD && p.RdE != '0 &&
                    (p.RdE == p.Rs1D || p.RdE == p.Rs2D);
  assign redirect = p.PCSrcE | p.Jump2E;
  assign active = state_q == RUN || state_q == STEP;
  // a redirect squashes the stalled instruction, so it overrides the load-use hold
  assign hold = lw_stall && !redirect;
  assign p.StallF = state_q == INIT || state_q == HALT || (active && hold);
  assign p.StallD = state_q == HALT || (active && hold);
  assign p.FlushD = state_q == INIT || (active && redirect);
  assign p.FlushE = state_q == INIT || state_q == HALT || (active && (lw_stall || redirect));
  assign p.step_ack = state_q == STEP && !hold;
  assign p.halted = halted_q;
  assign p.stall_count = cnt_q;
  always_comb begin
    state_d = state_q == INIT ? (init_q == '0 ? RUN : INIT) :
              state_q == RUN  ? (p.halt_req ? HALT : RUN) :
              state_q == HALT ? (p.resume_req ? RUN : p.step_req ? STEP : HALT) :
              (hold ? STEP : HALT);
    init_d = (state_q == INIT && init_q != '0) ? init_q - 4'd1 : init_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      init_q   <= INIT_LOAD;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      halted_q <= state_d == HALT;
      if (active && hold && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: randomized and directed checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int FC = 4;
  localparam int M_INIT = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int m_mode, m_init_left, m_cnt;
  pipeline_ctrl_if #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  pipeline_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .p(bus)
  );
  always #5 clk = ~clk;

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
    if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
    if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_lw();
    return bus.ResultSrcE == 2'h1 && bus.RdE != 0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
  endfunction

  function automatic bit ref_rd();
    return bus.PCSrcE || bus.Jump2E;
  endfunction

  function automatic logic [13:0] model_exp();
    logic [3:0] ctl;
    bit stalled;
    stalled = ref_lw() && !ref_rd();
    if (m_mode == M_INIT) ctl = 4'b1011;
    else if (m_mode == M_HALT) ctl = 4'b1101;
    else if (ref_rd()) ctl = 4'b0011;
    else if (ref_lw()) ctl = 4'b1101;
    else ctl = 4'b0000;
    return {ref_fwd(bus.Rs1E), ref_fwd(bus.Rs2E), ctl, m_mode == M_HALT,
            m_mode == M_STEP && !stalled, 4'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_mode = M_INIT;
    m_init_left = FC;
    m_cnt = 0;
  endtask

  task automatic model_advance();
    bit stalled;
    stalled = ref_lw() && !ref_rd();
    if ((m_mode == M_RUN || m_mode == M_STEP) && stalled && m_cnt < 15) m_cnt++;
    case (m_mode)
      M_INIT: begin m_init_left--; if (m_init_left == 0) m_mode = M_RUN; end
      M_RUN:  if (bus.halt_req) m_mode = M_HALT;
      M_HALT: m_mode = bus.resume_req ? M_RUN : bus.step_req ? M_STEP : M_HALT;
      default: m_mode = stalled ? M_STEP : M_HALT;
    endcase
  endtask

  task automatic clear_inputs();
    {bus.Rs1D, bus.Rs2D, bus.Rs1E, bus.Rs2E, bus.RdE, bus.RdM, bus.RdW} = '0;
    {bus.RegWriteM, bus.RegWriteW, bus.PCSrcE, bus.Jump2E} = '0;
    bus.ResultSrcE = 2'h0;
    {bus.halt_req, bus.step_req, bus.resume_req} = '0;
  endtask

  task automatic random_inputs(input bit ctl);
    bus.Rs1D = AW'($urandom_range(0, 3)); bus.Rs2D = AW'($urandom_range(0, 3));
    bus.Rs1E = AW'($urandom_range(0, 3)); bus.Rs2E = AW'($urandom_range(0, 3));
    bus.RdE = AW'($urandom_range(0, 3)); bus.RdM = AW'($urandom_range(0, 3));
    bus.RdW = AW'($urandom_range(0, 3));
    bus.RegWriteM = 1'($urandom_range(0, 1)); bus.RegWriteW = 1'($urandom_range(0, 1));
    bus.ResultSrcE = ctl ? 2'($urandom_range(0, 3)) : 2'h0;
    bus.PCSrcE = ctl && $urandom_range(0, 5) == 0;
    bus.Jump2E = ctl && $urandom_range(0, 7) == 0;
    bus.halt_req = ctl && $urandom_range(0, 9) == 0;
    bus.step_req = ctl && $urandom_range(0, 3) == 0;
    bus.resume_req = ctl && $urandom_range(0, 5) == 0;
  endtask

  task automatic step_cycle(output logic [13:0] obs, output logic [13:0] exp);
    #2;
    obs = {bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE,
           bus.halted, bus.step_ack, bus.stall_count};
    exp = model_exp();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [13:0] obs, exp;
    clear_inputs();
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    obs = {bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE,
           bus.halted, bus.step_ack, bus.stall_count};
    tests++;
    if (obs !== 14'b00_00_1011_00_0000) begin
      fails++; $display("FAIL reset_async: got %b want %b", obs, 14'b00_00_1011_00_0000);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < FC + 2; i++) begin
      step_cycle(obs, exp);
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL reset_flush[%0d]: got %b want %b", i, obs, exp); end
    end
    tests++;
    if (obs[9:6] !== 4'b0000) begin fails++; $display("FAIL reset_run: got %b want 0000", obs[9:6]); end
  endtask

  task automatic test_forwarding();
    logic [13:0] obs, exp;
    clear_inputs();
    bus.RdM = 5; bus.RegWriteM = 1; bus.RdW = 5; bus.RegWriteW = 1; bus.Rs1E = 5; bus.Rs2E = 7;
    step_cycle(obs, exp);
    tests++;
    if (obs[13:10] !== 4'b1000 || obs !== exp) begin
      fails++; $display("FAIL fwd_mem: got %b want %b (AE/BE 1000)", obs, exp);
    end
    bus.RdM = 0;
    step_cycle(obs, exp);
    tests++;
    if (obs[13:10] !== 4'b0100 || obs !== exp) begin
      fails++; $display("FAIL fwd_wb: got %b want %b (AE/BE 0100)", obs, exp);
    end
    for (int i = 0; i < 40; i++) begin
      random_inputs(1'b0);
      step_cycle(obs, exp);
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL fwd_rand[%0d]: got %b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_load_use();
    logic [13:0] obs, exp;
    clear_inputs();
    bus.ResultSrcE = 2'h1; bus.RdE = 3; bus.Rs2D = 3;
    step_cycle(obs, exp);
    tests++;
    if (obs[9:6] !== 4'b1101 || obs[3:0] !== 4'd0 || obs !== exp) begin
      fails++; $display("FAIL load_use: got %b want %b", obs, exp);
    end
    bus.PCSrcE = 1;
    step_cycle(obs, exp);
    tests++;
    if (obs[9:6] !== 4'b0011 || obs[3:0] !== 4'd1 || obs !== exp) begin
      fails++; $display("FAIL load_use_redirect: got %b want %b", obs, exp);
    end
    clear_inputs();
    step_cycle(obs, exp);
    tests++;
    if (obs[3:0] !== 4'd1 || obs !== exp) begin
      fails++; $display("FAIL load_use_count: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_debug();
    logic [13:0] obs, exp;
    clear_inputs();
    bus.halt_req = 1;
    step_cycle(obs, exp);
    bus.halt_req = 0;
    step_cycle(obs, exp);
    tests++;
    if (obs[9:4] !== 6'b110110 || obs !== exp) begin
      fails++; $display("FAIL halt_enter: got %b want %b", obs, exp);
    end
    bus.step_req = 1;
    step_cycle(obs, exp);
    bus.step_req = 0;
    step_cycle(obs, exp);
    tests++;
    if (obs[5:4] !== 2'b01 || obs !== exp) begin
      fails++; $display("FAIL step_ack: got %b want %b", obs, exp);
    end
    step_cycle(obs, exp);
    tests++;
    if (obs[5:4] !== 2'b10 || obs !== exp) begin
      fails++; $display("FAIL step_return: got %b want %b", obs, exp);
    end
    bus.resume_req = 1; bus.step_req = 1;
    step_cycle(obs, exp);
    clear_inputs();
    step_cycle(obs, exp);
    tests++;
    if (obs[5:4] !== 2'b00 || obs !== exp) begin
      fails++; $display("FAIL resume: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_saturation();
    logic [13:0] obs, exp;
    clear_inputs();
    @(negedge clk);
    #3 rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (FC) step_cycle(obs, exp);
    bus.ResultSrcE = 2'h1; bus.RdE = 9; bus.Rs1D = 9;
    for (int i = 0; i < 19; i++) begin
      step_cycle(obs, exp);
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL sat[%0d]: got %b want %b", i, obs, exp); end
    end
    tests++;
    if (obs[3:0] !== 4'hF) begin fails++; $display("FAIL sat_hold: got %h want f", obs[3:0]); end
  endtask

  task automatic test_random();
    logic [13:0] obs, exp;
    for (int i = 0; i < 400; i++) begin
      random_inputs(1'b1);
      step_cycle(obs, exp);
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL rand[%0d]: got %b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_reset_mid_step();
    logic [13:0] obs, exp;
    int guard;
    clear_inputs();
    guard = 0;
    while (m_mode != M_RUN && guard < 50) begin
      bus.resume_req = 1;
      step_cycle(obs, exp);
      guard++;
    end
    clear_inputs();
    bus.halt_req = 1;
    step_cycle(obs, exp);
    clear_inputs();
    bus.step_req = 1; bus.ResultSrcE = 2'h1; bus.RdE = 3; bus.Rs1D = 3;
    step_cycle(obs, exp);
    bus.step_req = 0;
    step_cycle(obs, exp);
    tests++;
    if (obs[5:4] !== 2'b00 || obs !== exp || m_mode != M_STEP) begin
      fails++; $display("FAIL step_stalled: got %b want %b", obs, exp);
    end
    #3 rst = 1'b1;
    #1;
    obs = {bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE,
           bus.halted, bus.step_ack, bus.stall_count};
    tests++;
    if (obs !== 14'b00_00_1011_00_0000) begin
      fails++; $display("FAIL reset_mid_step: got %b want %b", obs, 14'b00_00_1011_00_0000);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < FC + 2; i++) begin
      step_cycle(obs, exp);
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL post_reset[%0d]: got %b want %b", i, obs, exp); end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_debug();
    test_saturation();
    test_random();
    test_reset_mid_step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, register-index width.
REQ-002 Parameter CNT_WIDTH, default 16, stall-counter width.
REQ-003 Parameter FLUSH_CYCLES, default 4, post-reset bubble cycles; legal range 2..15.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 Rs1D, Rs2D  input  REG_ADDR_WIDTH  source indices in Decode.
REQ-008 Rs1E, Rs2E, RdE  input  REG_ADDR_WIDTH  source/dest indices in Execute.
REQ-009 RdM, RdW  input  REG_ADDR_WIDTH  dest indices in Memory/Writeback.
REQ-010 RegWriteM, RegWriteW  input  1  register-write enables, Memory/Writeback.
REQ-011 ResultSrcE  input  2  result select in Execute; 2'h1 = load.
REQ-012 PCSrcE, Jump2E  input  1  branch/JAL redirect and JALR redirect from Execute.
REQ-013 halt_req, step_req, resume_req  input  1  debug run-control pulses.
REQ-014 ForwardAE, ForwardBE  output  2  ALU operand source: 00 regfile, 01 ResultW, 10 ALUResultM.
REQ-015 StallF, StallD  output  1  hold PC register / F-D register.
REQ-016 FlushD, FlushE  output  1  clear F-D / D-E register to a bubble next edge.
REQ-017 halted  output  1  high in HALT state.
REQ-018 step_ack  output  1  one-cycle pulse on step completion.
REQ-019 stall_count  output  CNT_WIDTH  saturating count of load-use stall cycles.

Function
REQ-020 ForwardAE SHALL be 10 if RegWriteM, RdM!=0, RdM==Rs1E; else 01 if RegWriteW, RdW!=0, RdW==Rs1E; else 00 (Memory beats Writeback); ForwardBE identically with Rs2E; combinational, all states.
REQ-021 lwStall SHALL be ResultSrcE==2'h1, RdE!=0, and RdE equals Rs1D or Rs2D.
REQ-022 redirect SHALL be PCSrcE or Jump2E.
REQ-023 FSM states: INIT, RUN, HALT, STEP.
REQ-024 INIT: StallF=1, StallD=0, FlushD=1, FlushE=1; down-counter from FLUSH_CYCLES-1, go RUN when it reaches 0; halt_req/step_req/resume_req ignored.
REQ-025 RUN/STEP: StallF=StallD=lwStall and not redirect; FlushD=redirect; FlushE=lwStall or redirect (redirect beats stall on simultaneous events).
REQ-026 RUN: halt_req SHALL move to HALT next edge; that cycle's outputs follow REQ-025.
REQ-027 HALT: StallF=StallD=1, FlushD=0, FlushE=1; M/W drain naturally.
REQ-028 HALT priority: resume_req -> RUN; else step_req -> STEP; else stay.
REQ-029 STEP SHALL last one cycle, return to HALT, and assert step_ack that cycle; if lwStall holds in STEP, stay in STEP, step_ack low, until a non-stalled cycle.
REQ-030 step_req/resume_req outside HALT, and halt_req outside RUN, SHALL be ignored.
REQ-031 stall_count SHALL increment on each edge with state RUN/STEP, lwStall=1, redirect=0; saturate at all-ones, never wrap.
REQ-032 halted SHALL be a registered decode of state (high exactly while in HALT).

Reset
REQ-033 rst asserted SHALL immediately force state INIT, init counter FLUSH_CYCLES-1, stall_count 0, step_ack 0, halted 0, independent of clk.
REQ-034 Reset mid-HALT or mid-STEP SHALL abandon it; no step_ack follows.
REQ-035 Combinational outputs during reset SHALL follow INIT values (StallF=1, FlushD=1, FlushE=1, StallD=0).

Structure
REQ-036 Package pipeline_ctrl_pkg SHALL hold the state enum, FWD_RF/FWD_W/FWD_M encodings, and RESULT_SRC_LOAD=2'h1; included alongside other shared headers.
REQ-037 One sub-module fwd_sel (index, RdM, RdW, enables -> 2-bit select), instantiated twice.

Verification
REQ-038 rst pulse, FLUSH_CYCLES=4 -> StallF/FlushD/FlushE high for 4 edges after release, then RUN with all low.
REQ-039 RUN, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; RdM=0 same case -> 01; Rs2E=7 -> ForwardBE=00.
REQ-040 RUN, ResultSrcE=2'h1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1, FlushD=0, stall_count 0->1; add PCSrcE=1 -> StallF=0, FlushD=FlushE=1, count unchanged.
REQ-041 halt_req in RUN -> halted=1 next edge, StallF=StallD=FlushE=1; step_req -> one STEP cycle, step_ack pulse, back to HALT; resume_req with step_req -> RUN, no step_ack.
REQ-042 Preload stall_count to all-ones (CNT_WIDTH=4, 15 stall cycles) then 3 more -> stays 4'hF; async rst mid-STEP -> INIT same cycle, step_ack 0.
